// File: rtl/seq_div_pkg.sv
// Shared widths, counter size and FSM encoding for the sequential restoring divider.
package seq_div_pkg;
  localparam int WIDTH_N_DEF = 16;
  localparam int WIDTH_D_DEF = 8;
  localparam int CNT_W_DEF   = $clog2(WIDTH_N_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_div_16_8_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Zero latency, no flow control; reusable by unrolled or pipelined variants.
module div_step
  import seq_div_pkg::*;
#(
  parameter int WIDTH_D = WIDTH_D_DEF
) (
  input  logic [WIDTH_D:0]   part_in,
  input  logic               bit_in,
  input  logic [WIDTH_D-1:0] divisor,
  output logic [WIDTH_D:0]   part_out,
  output logic               q_bit
);
  logic [WIDTH_D:0] shifted;

  // part_in stays below the divisor, so its top bit only matters if a caller breaks that invariant
  always_comb begin
    shifted  = {part_in[WIDTH_D-1:0], bit_in};
    q_bit    = part_in[WIDTH_D] || (shifted >= {1'b0, divisor});
    part_out = q_bit ? (shifted - {1'b0, divisor}) : shifted;
  end
endmodule

// File: rtl/seq_div_16_8.sv
// Iterative unsigned 16/8 divider: 16 cycles accept-to-valid (next cycle for divide-by-zero).
// Accepts only in IDLE; result held in DONE until out_ready, then returns to IDLE.
module seq_div_16_8
  import seq_div_pkg::*;
#(
  parameter int WIDTH_N = WIDTH_N_DEF,
  parameter int WIDTH_D = WIDTH_D_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               div_by_zero
);
  localparam int CNT_W = $clog2(WIDTH_N);

  state_t             state_q, state_d;
  logic [WIDTH_N-1:0] dvd_q, dvd_d;
  logic [WIDTH_D-1:0] dvs_q, dvs_d;
  logic [WIDTH_D:0]   part_q, part_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH_N-1:0] quotient_q, quotient_d;
  logic [WIDTH_D-1:0] remainder_q, remainder_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH_D:0]   step_part;
  logic               step_q;

  div_step #(.WIDTH_D(WIDTH_D)) u_step (
    .part_in  (part_q),
    .bit_in   (dvd_q[WIDTH_N-1]),
    .divisor  (dvs_q),
    .part_out (step_part),
    .q_bit    (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = (divisor == '0) ? DONE : BUSY;
      BUSY:    if (cnt_q == '0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Dividend register doubles as the quotient shift register: MSBs leave, quotient bits enter at the LSB
  always_comb begin
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    part_d      = part_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          part_d = '0;
          cnt_d  = CNT_W'(WIDTH_N - 1);
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend[WIDTH_D-1:0];
            dbz_d       = 1'b1;
          end
        end
      end
      BUSY: begin
        dvd_d  = {dvd_q[WIDTH_N-2:0], step_q};
        part_d = step_part;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          quotient_d  = {dvd_q[WIDTH_N-2:0], step_q};
          remainder_d = step_part[WIDTH_D-1:0];
          dbz_d       = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      part_q      <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      part_q      <= part_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_div_16_8.sv
// Directed and randomized checks of seq_div_16_8 against a plain-arithmetic division model.
module tb_seq_div_16_8;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int compared   = 0;
  int mismatched = 0;

  seq_div_16_8 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, compared=%0d", compared);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, wait for its result, apply backpressure for 'hold' cycles, then retire it.
  task automatic run_op(input string tag, input logic [15:0] n, input logic [7:0] d,
                        input int hold, input int pre_gap, input bit noisy);
    int          waitc;
    int          lat;
    int          ni;
    int          di;
    logic [15:0] eq;
    logic [7:0]  er;
    logic        edbz;
    ni = int'(n);
    di = int'(d);
    if (di == 0) begin
      eq   = 16'hFFFF;
      er   = 8'(ni % 256);
      edbz = 1'b1;
    end else begin
      eq   = 16'(ni / di);
      er   = 8'(ni % di);
      edbz = 1'b0;
    end

    in_valid = 1'b0;
    for (int g = 0; g < pre_gap; g++) begin
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      tick();
    end
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      tick();
      waitc++;
    end
    chk({tag, ".in_ready_before"}, 32'(in_ready), 32'd1);

    dividend  = n;
    divisor   = d;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    tick();

    in_valid = noisy;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), (di == 0) ? 32'd0 : 32'd16);
    chk({tag, ".quotient"}, 32'(quotient), 32'(eq));
    chk({tag, ".remainder"}, 32'(remainder), 32'(er));
    chk({tag, ".div_by_zero"}, 32'(div_by_zero), 32'(edbz));
    chk({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);

    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_quotient"}, 32'(quotient), 32'(eq));
      chk({tag, ".hold_remainder"}, 32'(remainder), 32'(er));
      chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end

    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({tag, ".retire_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".retire_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] rn;
    logic [7:0]  rd;
    logic [7:0]  ra;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    tick();
    tick();
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.quotient", 32'(quotient), 32'd0);
    chk("reset.remainder", 32'(remainder), 32'd0);
    chk("reset.div_by_zero", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    tick();

    run_op("d100_7", 16'd100, 8'd7, 0, 0, 1'b0);
    run_op("d65535_1", 16'd65535, 8'd1, 0, 1, 1'b0);
    run_op("d65025_255", 16'd65025, 8'd255, 0, 0, 1'b1);
    run_op("d1234_0", 16'h04D2, 8'd0, 0, 0, 1'b0);
    run_op("d5000_13_bp", 16'd5000, 8'd13, 5, 0, 1'b1);

    in_valid = 1'b1;
    dividend = 16'd40000;
    divisor  = 8'd3;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.quotient", 32'(quotient), 32'd0);
    chk("midrst.remainder", 32'(remainder), 32'd0);
    chk("midrst.div_by_zero", 32'(div_by_zero), 32'd0);
    repeat (20) tick();
    chk("midrst.no_stale_result", 32'(out_valid), 32'd0);
    run_op("d9_4", 16'd9, 8'd4, 0, 0, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      rd = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(3) == 0) begin
        ra = 8'($urandom);
        rn = 16'(int'(ra) * int'(rd));
      end else begin
        rn = 16'($urandom);
      end
      run_op("rand", rn, rd, $urandom_range(3), $urandom_range(3), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
